display_scanout: RTL and testbench

DISPLAY_SCANOUT -- requirements
Module: display_scanout

---
 rtl/vga_timing_pkg.sv | 24 ++
 rtl/display_scanout_if.sv | 11 +
 rtl/vga_timing_gen.sv | 58 +++++
 rtl/display_scanout.sv | 59 +++++
 tb/tb_display_scanout.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing defaults (640x480@60) and pixel/control types for scanout and pane writer.
// Declarations only: no logic, no latency, no flow control.
package vga_timing_pkg;
  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam int H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  typedef logic [23:0] rgb_t;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic blank;
    logic frame_start;
  } vid_ctl_t;
endpackage

// File: rtl/display_scanout_if.sv
// Pixel FIFO read port (first-word-fall-through head, empty flag, pop strobe).
// The FIFO side owns data/empty; the scanout side owns the pop strobe.
interface display_scanout_if;
  import vga_timing_pkg::*;
  rgb_t data_in;
  logic empty;
  logic rd_en;

  modport master (output data_in, output empty, input rd_en);
  modport slave  (input data_in, input empty, output rd_en);
endinterface

// File: rtl/vga_timing_gen.sv
// Free-running h/v pixel counters with combinational active/sync/first-pixel decode.
// Zero latency from counter state; never stalls, so FIFO underflow cannot shift timing.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic clk,
  input  logic rst,
  output logic active,
  output logic hsync_n,
  output logic vsync_n,
  output logic first
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  // Every bound is pre-sized to the counter width so all compares are same-width unsigned.
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_FIRST = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_LAST  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_FIRST = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_LAST  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
    end else begin
      h_cnt <= h_cnt + HW'(1);
    end
  end

  always_comb begin
    active  = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    hsync_n = !((h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST));
    vsync_n = !((v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST));
    first   = (h_cnt == '0) && (v_cnt == '0);
  end
endmodule

// File: rtl/display_scanout.sv
// VGA scanout: pops the pixel FIFO during active video and registers colour plus sync/blank.
// 1-cycle latency from counter state; an empty FIFO yields black and flags underflow, never stalls.
module display_scanout
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  display_scanout_if.slave         fifo,
  output rgb_t                     rgb,
  output logic                     hsync,
  output logic                     vsync,
  output logic                     blank,
  output logic                     frame_start,
  output logic                     underflow
);
  logic     active, hsync_n, vsync_n, first;
  vid_ctl_t ctl;

  vga_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk     (clk),
    .rst     (rst),
    .active  (active),
    .hsync_n (hsync_n),
    .vsync_n (vsync_n),
    .first   (first)
  );

  // Counters already sit at (0,0) during reset, so the pop must be masked explicitly.
  assign fifo.rd_en = active && !fifo.empty && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb       <= '0;
      ctl       <= '{hsync: 1'b1, vsync: 1'b1, blank: 1'b1, frame_start: 1'b0};
      underflow <= 1'b0;
    end else begin
      rgb       <= fifo.rd_en ? fifo.data_in : '0;
      ctl       <= '{hsync: hsync_n, vsync: vsync_n, blank: !active, frame_start: first};
      underflow <= underflow || (active && fifo.empty);
    end
  end

  assign hsync       = ctl.hsync;
  assign vsync       = ctl.vsync;
  assign blank       = ctl.blank;
  assign frame_start = ctl.frame_start;
endmodule

// File: tb/tb_display_scanout.sv
// Random-stimulus scoreboard bench for display_scanout with a reduced 14x7 raster.
module tb_display_scanout;
  import vga_timing_pkg::*;

  localparam int HA = 8, HF = 2, HS = 2, HB = 2;
  localparam int VA = 4, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  typedef struct packed {
    logic [23:0] rgb;
    logic        hs;
    logic        vs;
    logic        bl;
    logic        fs;
    logic        uf;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  rgb_t rgb;
  logic hsync, vsync, blank, frame_start, underflow;

  display_scanout_if bus ();

  display_scanout #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fifo        (bus),
    .rgb         (rgb),
    .hsync       (hsync),
    .vsync       (vsync),
    .blank       (blank),
    .frame_start (frame_start),
    .underflow   (underflow)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   pos    = 0;
  bit   uf_m   = 1'b0;
  exp_t q_out[$];
  bit   q_rd[$];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  // One pixel: drive FIFO inputs, predict the pop and the registered outputs from raster position.
  task automatic step(input logic [23:0] d, input logic e);
    int   x, y;
    bit   act;
    exp_t ex;
    @(negedge clk);
    bus.data_in = d;
    bus.empty   = e;
    x   = pos % HT;
    y   = pos / HT;
    act = (x < HA) && (y < VA);
    q_rd.push_back(act && !e);
    if (act && e) uf_m = 1'b1;
    ex.rgb = (act && !e) ? d : 24'h0;
    ex.hs  = !((x >= HA + HF) && (x < HA + HF + HS));
    ex.vs  = !((y >= VA + VF) && (y < VA + VF + VS));
    ex.bl  = !act;
    ex.fs  = (pos == 0);
    ex.uf  = uf_m;
    q_out.push_back(ex);
    pos = (pos + 1) % FT;
  endtask

  // mode 0: fixed colour, full FIFO in active video, random empty in blanking
  // mode 1: random colour, same FIFO pattern; mode 2: two-pixel underflow at (3..4,0)
  // mode 3: everything random
  task automatic run(input int n, input int mode);
    int          x, y;
    bit          act;
    logic [23:0] d;
    logic        e;
    for (int i = 0; i < n; i++) begin
      x   = pos % HT;
      y   = pos / HT;
      act = (x < HA) && (y < VA);
      d   = 24'($urandom);
      e   = 1'b0;
      case (mode)
        0: begin d = 24'hAABBCC; e = act ? 1'b0 : 1'($urandom_range(0, 1)); end
        1: e = act ? 1'b0 : 1'($urandom_range(0, 1));
        2: e = (y == 0) && (x == 3 || x == 4);
        default: e = ($urandom_range(0, 3) == 0);
      endcase
      step(d, e);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_rgb"},   32'(rgb),         32'h0);
    chk({tag, "_hsync"}, 32'(hsync),       32'h1);
    chk({tag, "_vsync"}, 32'(vsync),       32'h1);
    chk({tag, "_blank"}, 32'(blank),       32'h1);
    chk({tag, "_fs"},    32'(frame_start), 32'h0);
    chk({tag, "_uf"},    32'(underflow),   32'h0);
    chk({tag, "_rd_en"}, 32'(bus.rd_en),   32'h0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    bus.empty = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_vals("async_rst");
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_rd_en", 32'(bus.rd_en), 32'h0);
    #2;
    rst  = 1'b0;
    pos  = 0;
    uf_m = 1'b0;
  endtask

  initial begin : mon_out
    exp_t ex, got;
    forever begin
      @(posedge clk);
      #1;
      if (q_out.size() > 0) begin
        ex  = q_out.pop_front();
        got = {rgb, hsync, vsync, blank, frame_start, underflow};
        checks++;
        if (got !== ex) begin
          errors++;
          $display("FAIL out t=%0t rgb=%h/%h hs=%b/%b vs=%b/%b bl=%b/%b fs=%b/%b uf=%b/%b (got/exp)",
                   $time, got.rgb, ex.rgb, got.hs, ex.hs, got.vs, ex.vs,
                   got.bl, ex.bl, got.fs, ex.fs, got.uf, ex.uf);
        end
      end
    end
  end

  initial begin : mon_rd
    bit er;
    forever begin
      @(negedge clk);
      #2;
      if (q_rd.size() > 0) begin
        er = q_rd.pop_front();
        chk("rd_en", 32'(bus.rd_en), 32'(er));
      end
    end
  end

  initial begin : watchdog
    #200000;
    errors++;
    $display("FAIL timeout checks=%0d", checks);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

  initial begin : main
    rst         = 1'b1;
    bus.data_in = 24'h0;
    bus.empty   = 1'b0;
    #3;
    check_reset_vals("init_rst");
    @(posedge clk);
    #3;
    rst = 1'b0;

    run(FT, 0);
    run(FT, 1);
    run(FT, 2);
    run(33, 1);
    do_reset();
    run(FT, 0);
    run(3 * FT, 3);

    @(posedge clk);
    #5;
    chk("drain_out", 32'(q_out.size()), 32'h0);
    chk("drain_rd",  32'(q_rd.size()),  32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
